param_up_down_counter: RTL and testbench



---
 rtl/udc_pkg.sv | 23 ++
 rtl/udc_next_state.sv | 52 +++++
 rtl/param_up_down_counter.sv | 83 ++++++++
 tb/tb_param_up_down_counter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared definitions for the parametrised up/down counter (udc) family.
// Holds the boundary-mode and direction encodings plus the load clamp helper
// used by udc_next_state.
package udc_pkg;

   // Boundary behaviour selected by the SATURATE parameter.
   localparam int UDC_WRAP = 0;
   localparam int UDC_SAT  = 1;

   // Count direction as carried on the up_down input.
   typedef enum logic {
      UDC_DOWN = 1'b0,
      UDC_UP   = 1'b1
   } udc_dir_e;

   // Limits a requested value to the highest legal count.
   // Works on 32-bit quantities so any counter width up to 32 can use it.
   function automatic logic [31:0] udcClamp(input logic [31:0] value,
                                            input logic [31:0] maxVal);
      return (value > maxVal) ? maxVal : value;
   endfunction

endpackage

// File: rtl/udc_next_state.sv
// Combinational next-count logic for param_up_down_counter.
// Resolves load > enable > hold priority, and reports whether the current
// enabled step tried to move past a boundary (drives rollover upstream).
module udc_next_state
   import udc_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 2**WIDTH-1,
   parameter int SATURATE = UDC_WRAP
)(
   input  logic [WIDTH-1:0] count,
   input  logic             en,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] next_count,
   output logic             boundary_hit
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] w_loadClamped;

   // Out-of-range load values are pulled down to the top of the count range.
   assign w_loadClamped = WIDTH'(udcClamp(32'(load_val), 32'(MAX_VAL)));

   // Boundary tests happen before the step, so the +1/-1 never leaves WIDTH bits.
   always_comb begin
      next_count   = count;
      boundary_hit = 1'b0;
      if (load) begin
         next_count = w_loadClamped;
      end else if (en) begin
         if (up_down == UDC_UP) begin
            if (count == MAX_C) begin
               boundary_hit = 1'b1;
               next_count   = (SATURATE == UDC_SAT) ? MAX_C : '0;
            end else begin
               next_count = count + WIDTH'(1);
            end
         end else begin
            if (count == '0) begin
               boundary_hit = 1'b1;
               next_count   = (SATURATE == UDC_SAT) ? '0 : MAX_C;
            end else begin
               next_count = count - WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with load, wrap/saturate boundaries,
// boundary decodes and a registered rollover pulse for cascading.
// Optional sticky overflow flag enabled by defining UDC_STICKY_OVF_EN.
module param_up_down_counter
   import udc_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_VAL   = 2**WIDTH-1,
   parameter int SATURATE  = UDC_WRAP,
   parameter int RESET_VAL = 0
)(
   input  logic             clk,
   input  logic             reset,
`ifdef UDC_STICKY_OVF_EN
   input  logic             ovf_clr,
   output logic             ovf_sticky,
`endif
   input  logic             en,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             rollover
);

   localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] r_count;
   logic             r_rollover;
   logic [WIDTH-1:0] w_nextCount;
   logic             w_boundaryHit;

   udc_next_state #(
      .WIDTH    (WIDTH),
      .MAX_VAL  (MAX_VAL),
      .SATURATE (SATURATE)
   ) u_nextState (
      .count        (r_count),
      .en           (en),
      .up_down      (up_down),
      .load         (load),
      .load_val     (load_val),
      .next_count   (w_nextCount),
      .boundary_hit (w_boundaryHit)
   );

   // Count register and rollover pulse; rollover is simply the registered boundary attempt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count    <= RESET_C;
         r_rollover <= 1'b0;
      end else begin
         r_count    <= w_nextCount;
         r_rollover <= w_boundaryHit;
      end
   end

`ifdef UDC_STICKY_OVF_EN
   logic r_ovfSticky;

   // Sticky overflow: set alongside rollover, cleared by ovf_clr, set wins a tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovfSticky <= 1'b0;
      end else if (w_boundaryHit) begin
         r_ovfSticky <= 1'b1;
      end else if (ovf_clr) begin
         r_ovfSticky <= 1'b0;
      end
   end

   assign ovf_sticky = r_ovfSticky;
`endif

   assign count    = r_count;
   assign rollover = r_rollover;
   assign at_max   = (r_count == MAX_C);
   assign at_min   = (r_count == '0);

endmodule

// File: tb/tb_param_up_down_counter.sv
// Self-checking bench for param_up_down_counter.
// Three instances share stimulus: wrap 0..9, saturate 0..9, and a full-range
// 3-bit wrap counter with a non-zero reset value. Define UDC_STICKY_OVF_EN to
// also check the sticky overflow flag.
module tb_param_up_down_counter;
   import udc_pkg::*;

   logic       clk;
   logic       reset;
   logic       en;
   logic       upDown;
   logic       load;
   logic       ovfClr;
   logic [3:0] loadVal;

   logic [3:0] count0;
   logic [3:0] count1;
   logic [2:0] count2;
   logic [2:0] atMax;
   logic [2:0] atMin;
   logic [2:0] rollover;
`ifdef UDC_STICKY_OVF_EN
   logic [2:0] sticky;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state, one slot per instance.
   int mCnt[3];
   int mRoll[3];
   int mSticky[3];
   int mMax[3]  = '{9, 9, 7};
   int mSat[3]  = '{0, 1, 0};
   int mRst[3]  = '{0, 0, 5};
   int mMask[3] = '{15, 15, 7};

   typedef struct {
      logic       e;
      logic       u;
      logic       l;
      logic [3:0] lv;
      int         expW;
      int         rollW;
      int         expS;
      int         rollS;
   } vec_t;

   vec_t tbl[14];

   param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(UDC_WRAP), .RESET_VAL(0)) dutWrap (
      .clk(clk), .reset(reset),
`ifdef UDC_STICKY_OVF_EN
      .ovf_clr(ovfClr), .ovf_sticky(sticky[0]),
`endif
      .en(en), .up_down(upDown), .load(load), .load_val(loadVal),
      .count(count0), .at_max(atMax[0]), .at_min(atMin[0]), .rollover(rollover[0])
   );

   param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(UDC_SAT), .RESET_VAL(0)) dutSat (
      .clk(clk), .reset(reset),
`ifdef UDC_STICKY_OVF_EN
      .ovf_clr(ovfClr), .ovf_sticky(sticky[1]),
`endif
      .en(en), .up_down(upDown), .load(load), .load_val(loadVal),
      .count(count1), .at_max(atMax[1]), .at_min(atMin[1]), .rollover(rollover[1])
   );

   param_up_down_counter #(.WIDTH(3), .MAX_VAL(7), .SATURATE(UDC_WRAP), .RESET_VAL(5)) dutFull (
      .clk(clk), .reset(reset),
`ifdef UDC_STICKY_OVF_EN
      .ovf_clr(ovfClr), .ovf_sticky(sticky[2]),
`endif
      .en(en), .up_down(upDown), .load(load), .load_val(loadVal[2:0]),
      .count(count2), .at_max(atMax[2]), .at_min(atMin[2]), .rollover(rollover[2])
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its expected value and log any failure.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model reset: everything back to its reset value.
   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mCnt[i]    = mRst[i];
         mRoll[i]   = 0;
         mSticky[i] = 0;
      end
   endtask

   // Model one clock edge from the current inputs using range arithmetic.
   task automatic modelStep();
      for (int i = 0; i < 3; i++) begin
         int n;
         int lv;
         if (load) begin
            lv       = int'(loadVal) & mMask[i];
            mCnt[i]  = (lv > mMax[i]) ? mMax[i] : lv;
            mRoll[i] = 0;
         end else if (en) begin
            n = mCnt[i] + (upDown ? 1 : -1);
            if (n > mMax[i] || n < 0) begin
               mRoll[i] = 1;
               if (mSat[i] != 0) n = (n < 0) ? 0 : mMax[i];
               else              n = (n + mMax[i] + 1) % (mMax[i] + 1);
            end else begin
               mRoll[i] = 0;
            end
            mCnt[i] = n;
         end else begin
            mRoll[i] = 0;
         end
         if (mRoll[i] != 0)  mSticky[i] = 1;
         else if (ovfClr)    mSticky[i] = 0;
      end
   endtask

   // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
   task automatic applyStimulus(input logic e, input logic u, input logic l,
                                input logic [3:0] lv, input logic c);
      en      = e;
      upDown  = u;
      load    = l;
      loadVal = lv;
      ovfClr  = c;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   // Check every instance against the model.
   task automatic checkAll(input string tag);
      int act[3];
      act[0] = int'(count0);
      act[1] = int'(count1);
      act[2] = int'(count2);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s.count[%0d]", tag, i), act[i], mCnt[i]);
         checkOutput($sformatf("%s.rollover[%0d]", tag, i), int'(rollover[i]), mRoll[i]);
         checkOutput($sformatf("%s.at_max[%0d]", tag, i), int'(atMax[i]), int'(mCnt[i] == mMax[i]));
         checkOutput($sformatf("%s.at_min[%0d]", tag, i), int'(atMin[i]), int'(mCnt[i] == 0));
`ifdef UDC_STICKY_OVF_EN
         checkOutput($sformatf("%s.sticky[%0d]", tag, i), int'(sticky[i]), mSticky[i]);
`endif
      end
   endtask

   // Synchronous-looking reset pulse spanning one clock edge.
   task automatic doReset();
      reset = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // Hand-computed vectors from reset (wrap & sat both start at 0)
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  9, 1, 0, 1};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'd0,  8, 0, 0, 1};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'd15, 9, 0, 9, 0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'd15, 9, 0, 9, 0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  0, 1, 9, 1};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1, 0, 9, 1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'd0,  1, 0, 9, 0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'd7,  7, 0, 7, 0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'd0,  8, 0, 8, 0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd0,  9, 0, 9, 0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 4'd0,  0, 1, 9, 1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd0,  9, 1, 8, 0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 4'd0,  9, 0, 8, 0};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 4'd0,  0, 0, 0, 0};

      reset = 1'b1; en = 1'b0; upDown = 1'b0; load = 1'b0; loadVal = '0; ovfClr = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.count0", int'(count0), 0);
      checkOutput("reset.count2", int'(count2), 5);
      checkAll("reset");
      reset = 1'b0;

      // Table-driven vectors
      for (int k = 0; k < 14; k++) begin
         applyStimulus(tbl[k].e, tbl[k].u, tbl[k].l, tbl[k].lv, 1'b0);
         checkOutput($sformatf("tbl%0d.wrap.count", k), int'(count0), tbl[k].expW);
         checkOutput($sformatf("tbl%0d.wrap.roll", k), int'(rollover[0]), tbl[k].rollW);
         checkOutput($sformatf("tbl%0d.wrap.at_max", k), int'(atMax[0]), int'(tbl[k].expW == 9));
         checkOutput($sformatf("tbl%0d.sat.count", k), int'(count1), tbl[k].expS);
         checkOutput($sformatf("tbl%0d.sat.roll", k), int'(rollover[1]), tbl[k].rollS);
         checkOutput($sformatf("tbl%0d.sat.at_min", k), int'(atMin[1]), int'(tbl[k].expS == 0));
      end

      // Count up 12 from reset: 1..9,0,1,2 with one rollover after 9->0
      doReset();
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
         checkOutput($sformatf("up%0d.wrap.count", k), int'(count0), k % 10);
         checkOutput($sformatf("up%0d.wrap.roll", k), int'(rollover[0]), int'(k == 10));
         checkAll($sformatf("up%0d", k));
      end

      // Count down from 0: 9,8,7
      doReset();
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
         checkOutput($sformatf("dn%0d.wrap.count", k), int'(count0), 10 - k);
         checkAll($sformatf("dn%0d", k));
      end

      // Saturate: load 7, up 5 -> 8,9,9,9,9 then down -> 8
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
      checkAll("satLoad");
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
         checkOutput($sformatf("sat%0d.count", k), int'(count1), (k >= 2) ? 9 : 7 + k);
         checkOutput($sformatf("sat%0d.roll", k), int'(rollover[1]), int'(k >= 3));
         checkAll($sformatf("sat%0d", k));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("satDown.count", int'(count1), 8);
      checkOutput("satDown.roll", int'(rollover[1]), 0);
      checkAll("satDown");

      // Asynchronous reset mid-cycle at count 5
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
      checkAll("preAsync");
      en = 1'b1; upDown = 1'b1; load = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("async.count0", int'(count0), 0);
      checkOutput("async.count2", int'(count2), 5);
      checkAll("async");
      @(posedge clk);
      #1;
      checkAll("asyncHeld");
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput("release.count0", int'(count0), 1);
      checkAll("release");

`ifdef UDC_STICKY_OVF_EN
      // Sticky overflow: set, hold, clear, set-wins-over-clear
      doReset();
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput("sticky.set", int'(sticky[0]), 1);
      checkAll("stickySet");
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
         checkOutput($sformatf("sticky.hold%0d", k), int'(sticky[0]), 1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      checkOutput("sticky.clr", int'(sticky[0]), 0);
      checkAll("stickyClr");
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
      checkOutput("sticky.setWins", int'(sticky[0]), 1);
      checkAll("stickySetWins");
`endif

      // Randomized run against the model
      doReset();
      for (int k = 0; k < 400; k++) begin
         applyStimulus(logic'($urandom_range(0, 3) != 0),
                       logic'($urandom_range(0, 1)),
                       logic'($urandom_range(0, 7) == 0),
                       4'($urandom_range(0, 15)),
                       logic'($urandom_range(0, 9) == 0));
         checkAll($sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
